ror_iter_unit: RTL and testbench

- Multi-cycle rotate-right unit for the execute stage; the right-rotate counterpart of the existing combinational rotate-left.
- Uses a logarithmic shifter that processes one bit of the rotate amount per clock, MSB first, so only one rotate stage exists in hardware.
- Operands enter through a valid/ready request port; the result leaves through a valid/ready response port.
- Exactly one operation is in flight at a time.

---
 rtl/ror_iter_unit.sv | 142 ++++++++++++++
 tb/tb_ror_iter_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ror_iter_unit.sv
// rtl/ror_iter_unit.sv - multi-cycle rotate-right unit, one rotate stage per clock, MSB-first
//
// Purpose:
//   Rotates in_1 right by in_2[SHAMT_W-1:0] using a single rotate stage. The
//   stage is reused once per clock, walking the amount bits from MSB to LSB.
//   Each operation takes exactly SHAMT_W clock edges, whatever the amount.
//   Only one operation is in flight at a time.
//
// Optional feature (macro ROR_DIR_SEL_EN):
//   Adds input dir. dir=1 selects rotate-left. The amount is negated modulo
//   2^SHAMT_W when the request is captured. Latency is unchanged.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   unit idle and able to accept a request
//   in_1       data to rotate (WIDTH)
//   in_2       rotate amount (WIDTH); only [SHAMT_W-1:0] is used
//   dir        (ROR_DIR_SEL_EN only) 1 = rotate-left, 0 = rotate-right
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_ror    rotated result (WIDTH)

module ror_iter_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
`ifdef ROR_DIR_SEL_EN
  input  logic             dir,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_ror
);

  localparam int STAGE_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SHAMT_W-1:0]   amt_q, amt_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic                 valid_q, valid_d;

  logic [SHAMT_W-1:0]   amt_in;
  logic [SHAMT_W-1:0]   rot_amt;
  logic [WIDTH-1:0]     rotated;

  // The upper amount bits are ignored by design.
  logic                 unused_in_2_hi;
  assign unused_in_2_hi = ^in_2[WIDTH-1:SHAMT_W];

`ifdef ROR_DIR_SEL_EN
  // A left rotate by n equals a right rotate by (WIDTH - n) mod WIDTH.
  assign amt_in = dir ? (SHAMT_W'(0) - in_2[SHAMT_W-1:0]) : in_2[SHAMT_W-1:0];
`else
  assign amt_in = in_2[SHAMT_W-1:0];
`endif

  // The single shared rotate stage rotates right by 2^stage. The data is
  // concatenated with itself, shifted right, and then truncated.
  assign rot_amt = SHAMT_W'(1) << stage_q;
  assign rotated = WIDTH'({data_q, data_q} >> rot_amt);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_ror   = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      stage_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    stage_d = stage_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_1;
          amt_d   = amt_in;
          stage_d = STAGE_W'(SHAMT_W - 1);
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (amt_q[stage_q]) begin
          data_d = rotated;
        end
        if (stage_q == '0) begin
          state_d = DONE;
          valid_d = 1'b1;
        end else begin
          stage_d = stage_q - STAGE_W'(1);
        end
      end

      DONE: begin
        // data_q is frozen here, so out_ror holds through back-pressure.
        // It also keeps its value after the handshake.
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ror_iter_unit.sv
// tb/tb_ror_iter_unit.sv - self-checking bench for ror_iter_unit

module tb_ror_iter_unit;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_1 = '0;
  logic [W-1:0]  in_2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_ror;
`ifdef ROR_DIR_SEL_EN
  logic          dir = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  ror_iter_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_1      (in_1),
    .in_2      (in_2),
`ifdef ROR_DIR_SEL_EN
    .dir       (dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ror   (out_ror)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It computes each result by plain arithmetic from the
  // request. Timing is modelled as a countdown of SW edges.
  function automatic logic [W-1:0] m_rotr(input logic [W-1:0] x, input int n);
    int k;
    k = n % W;
    if (k == 0) return x;
    return (x >> k) | (x << (W - k));
  endfunction

  function automatic int m_amount();
    int n;
    n = int'(in_2[SW-1:0]);
`ifdef ROR_DIR_SEL_EN
    if (dir) n = (W - n) % W;
`endif
    return n;
  endfunction

  int            m_phase;   // 0 idle, 1 busy, 2 done
  int            m_cnt;
  logic [W-1:0]  m_pending;
  logic [W-1:0]  m_ror;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= 0;
      m_cnt     <= 0;
      m_pending <= '0;
      m_ror     <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase   <= 1;
          m_cnt     <= SW - 1;
          m_pending <= m_rotr(in_1, m_amount());
        end
        1: if (m_cnt == 0) begin
          m_phase <= 2;
          m_ror   <= m_pending;
        end else begin
          m_cnt <= m_cnt - 1;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Compare the DUT against the model on every cycle.
  // out_ror holds intermediate data while busy, so it is not compared then.
  always @(negedge clk) begin
    chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
    chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
    if (m_phase != 1) chk("cyc_out_ror", out_ror, m_ror);
  end

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input logic early, input int hold);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_1 = a; in_2 = b; out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, 5);
    chk({name, "_result"}, out_ror, exp);
    if (early) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1; in_1 = 32'hFFFF_FFFF; in_2 = 32'h3;
        @(posedge clk); #1;
        chk({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, "_hold_ror"}, out_ror, exp);
        chk({name, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk({name, "_post_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_post_ror"}, out_ror, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_ror", out_ror, 32'd0);
    rst_n = 1'b1;

    do_op("ror1",   32'h8000_0001, 32'h0000_0001, 32'hC000_0000, 1'b0, 0);
    do_op("hibits", 32'h1234_5678, 32'h0000_0024, 32'h8123_4567, 1'b0, 0);
    do_op("amt0",   32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0);
    do_op("amt31",  32'h0000_0001, 32'd31,        32'h0000_0002, 1'b0, 0);
    do_op("hold",   32'h000F_00F0, 32'd4,         32'h0000_F00F, 1'b0, 3);
    do_op("early",  32'hF000_0000, 32'd28,        32'h0000_000F, 1'b1, 0);
    do_op("amt16",  32'hABCD_1234, 32'd16,        32'h1234_ABCD, 1'b0, 1);

    // Reset during BUSY, after two stages.
    @(posedge clk); #1;
    in_valid = 1'b1; in_1 = 32'h1357_9BDF; in_2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_out_ror", out_ror, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midreset_no_valid", {31'b0, out_valid}, 32'd0);
    end
    do_op("after_rst", 32'hA5A5_A5A5, 32'd8, 32'hA5A5_A5A5, 1'b0, 0);

`ifdef ROR_DIR_SEL_EN
    dir = 1'b1;
    do_op("rol1", 32'h8000_0001, 32'd1, 32'h0000_0003, 1'b0, 0);
    do_op("rol0", 32'hCAFE_F00D, 32'd0, 32'hCAFE_F00D, 1'b0, 0);
    dir = 1'b0;
    do_op("dir0", 32'h8000_0001, 32'd1, 32'hC000_0000, 1'b0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
